rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 23 ++
 rtl/rr_arbiter4.sv | 107 ++++++++++
 tb/tb_rr_arbiter4.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: sizes, FSM encoding
// and a small index-to-one-hot helper.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PTR_W   = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StGap   = 2'b10
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: returns the first set req bit at or after ptr,
// scanning upward modulo NUM_REQ.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    // Walk from the farthest offset down so the nearest candidate wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + PTR_W'(i)]) begin
        idx = ptr + PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant, a
// one-cycle gap between grants and a hold-time limit that revokes stuck grants.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [PTR_W-1:0]   gnt_id,
  output logic               timeout
);

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;

  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic             rel;
  logic             expire;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign rel    = done[gnt_id_q] | ~req[gnt_id_q];
  assign expire = (hold_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle, StGap: begin
        hold_d = '0;
        if (pick_found) begin
          state_d  = StGrant;
          gnt_d    = idx_to_onehot(pick_idx);
          gnt_id_d = pick_idx;
        end else begin
          state_d  = StIdle;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      StGrant: begin
        if (rel || expire) begin
          state_d   = StGap;
          gnt_d     = '0;
          gnt_id_d  = '0;
          hold_d    = '0;
          ptr_d     = gnt_id_q + PTR_W'(1);
          // A release coinciding with expiry is treated as a normal release.
          timeout_d = ~rel;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d  = StIdle;
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed, table-driven bench for rr_arbiter4 (HOLD_MAX = 4) with a few
// hand-written reset sequences.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       to;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (oh[k]) r = 2'(k);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] exp_gnt, input logic exp_to);
    logic [1:0] exp_id;
    logic       exp_valid;
    exp_id    = oh_idx(exp_gnt);
    exp_valid = (exp_gnt != 4'b0000);
    checks++;
    if (gnt !== exp_gnt || gnt_valid !== exp_valid || gnt_id !== exp_id || timeout !== exp_to)
    begin
      errors++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d timeout=%b, want gnt=%b valid=%b id=%0d timeout=%b",
               name, gnt, gnt_valid, gnt_id, timeout, exp_gnt, exp_valid, exp_id, exp_to);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Round robin over all four, done two cycles into each grant.
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0001, 4'b0000, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0};
    vecs[5]  = '{4'b1111, 4'b0010, 4'b0000, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0100, 4'b0000, 1'b0};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0};
    vecs[10] = '{4'b1111, 4'b0000, 4'b1000, 1'b0};
    vecs[11] = '{4'b1111, 4'b1000, 4'b0000, 1'b0};
    vecs[12] = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    vecs[13] = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    vecs[14] = '{4'b1111, 4'b0001, 4'b0000, 1'b0};
    // Foreign done ignored, own done releases.
    vecs[15] = '{4'b0010, 4'b0000, 4'b0010, 1'b0};
    vecs[16] = '{4'b0010, 4'b0001, 4'b0010, 1'b0};
    vecs[17] = '{4'b0010, 4'b0010, 4'b0000, 1'b0};
    // ptr=2 with req 0011 wraps to 0, then 1; dropping req releases.
    vecs[18] = '{4'b0011, 4'b0000, 4'b0001, 1'b0};
    vecs[19] = '{4'b0011, 4'b0001, 4'b0000, 1'b0};
    vecs[20] = '{4'b0011, 4'b0000, 4'b0010, 1'b0};
    vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[22] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[23] = '{4'b0000, 4'b1111, 4'b0000, 1'b0};
    // Hold limit: four grant cycles, timeout gap, re-grant.
    vecs[24] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[25] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[26] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[27] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[28] = '{4'b0100, 4'b0000, 4'b0000, 1'b1};
    vecs[29] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    // Release on the expiry cycle: gap without timeout.
    vecs[30] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[31] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[32] = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[33] = '{4'b0100, 4'b0100, 4'b0000, 1'b0};
    vecs[34] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};

    reset_n = 1'b1;
    req     = 4'b0000;
    done    = 4'b0000;
    #2 reset_n = 1'b0;
    #1 check("reset_state", 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].to);
    end

    // Reset mid-grant clears gnt immediately; req 1000 granted one cycle later.
    step(4'b1000, 4'b0000);
    check("grant3_before_reset", 4'b1000, 1'b0);
    step(4'b1000, 4'b0000);
    check("grant3_hold", 4'b1000, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("async_reset_midgrant", 4'b0000, 1'b0);
    @(posedge clk);
    #1 check("reset_held", 4'b0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("grant_after_reset", 4'b1000, 1'b0);

    // Leave ptr at 3 with a live grant, reset, then requester 1 must beat 3.
    step(4'b1000, 4'b1000);
    check("release3", 4'b0000, 1'b0);
    step(4'b0100, 4'b0000);
    check("grant2_from_ptr0", 4'b0100, 1'b0);
    step(4'b0100, 4'b0100);
    check("release2", 4'b0000, 1'b0);
    step(4'b1010, 4'b0000);
    check("grant3_from_ptr3", 4'b1000, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("async_reset_ptr3", 4'b0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1010, 4'b0000);
    check("ptr_reset_priority", 4'b0010, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
